wb_daq_dma_master: RTL and testbench

WB_DAQ_DMA_MASTER -- requirements
Module: wb_daq_dma_master

---
 rtl/wb_daq_pkg.sv | 25 ++
 rtl/wb_daq_rr_arbiter.sv | 52 +++++
 rtl/wb_daq_dma_master.sv | 200 ++++++++++++++++++++
 tb/tb_wb_daq_dma_master.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_daq_pkg.sv
// Shared definitions for the Wibone DAQ DMA master: FSM encoding, control_reg
// bit positions and Wishbone cycle-type constants.
package wb_daq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARB       = 2'd1,
        ST_WRITE     = 2'd2,
        ST_RETRY_GAP = 2'd3
    } daq_state_e;

    localparam int ENABLE_BIT  = 0;
    localparam int CLR_ERR_BIT = 1;
    localparam int MASK_LSB    = 8;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [3:0] SEL_ALL     = 4'hF;

    // Channel index reached by stepping 'off' places past 'base' in a ring of n.
    function automatic int rr_wrap(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/wb_daq_rr_arbiter.sv
// Round-robin arbiter: one-hot grant over masked requests, searching from the
// channel after the last accepted one. Pointer resets to NUM_CH-1.
module wb_daq_rr_arbiter
    import wb_daq_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] mask,
    input  logic              accept,
    output logic [NUM_CH-1:0] grant
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [IDX_W-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  idx_s, pick_s;
    logic [NUM_CH-1:0] cand_s, grant_s;
    logic              hit_s, found_s;

    // First masked request at or after last+1, wrapping around the ring.
    always_comb begin
        cand_s  = req & mask;
        grant_s = {NUM_CH{1'b0}};
        found_s = 1'b0;
        hit_s   = 1'b0;
        idx_s   = last_q;
        pick_s  = last_q;
        for (int off = 1; off <= NUM_CH; off++) begin
            idx_s          = IDX_W'(rr_wrap(int'(last_q), off, NUM_CH));
            hit_s          = ~found_s & cand_s[idx_s];
            grant_s[idx_s] = grant_s[idx_s] | hit_s;
            pick_s         = hit_s ? idx_s : pick_s;
            found_s        = found_s | hit_s;
        end
        last_d = (accept & found_s) ? pick_s : last_q;
    end

    // Last-served pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= IDX_W'(NUM_CH - 1);
        end else begin
            last_q <= last_d;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/wb_daq_dma_master.sv
// Write-only Wishbone master moving channel samples into a ring buffer.
// Define WB_DAQ_ERR_RETRY_EN to reissue errored writes up to MAX_RETRY times.
module wb_daq_dma_master
    import wb_daq_pkg::*;
#(
    parameter int dw        = 32,
    parameter int aw        = 32,
    parameter int NUM_CH    = 4,
    parameter int PTR_W     = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    output logic [aw-1:0]        wb_adr_o,
    output logic [dw-1:0]        wb_dat_o,
    output logic [3:0]           wb_sel_o,
    output logic                 wb_we_o,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic [2:0]           wb_cti_o,
    output logic [1:0]           wb_bte_o,
    input  logic [dw-1:0]        wb_dat_i,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i,
    input  logic                 wb_rty_i,
    input  logic [dw-1:0]        control_reg,
    input  logic [aw-1:0]        base_addr,
    input  logic [PTR_W-1:0]     buf_words,
    input  logic [NUM_CH-1:0]    ch_valid,
    input  logic [NUM_CH*dw-1:0] ch_data,
    output logic [NUM_CH-1:0]    ch_ready,
    output logic [PTR_W-1:0]     wr_ptr,
    output logic                 busy,
    output logic                 err_o,
    output logic                 wrap_irq
);

    daq_state_e        state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [aw-1:0]     adr_q, adr_d;
    logic [dw-1:0]     dat_q, dat_d;
    logic              cyc_q, cyc_d;
    logic              err_q, err_d;
    logic              wrap_q, wrap_d;
`ifdef WB_DAQ_ERR_RETRY_EN
    logic [7:0]        retry_q, retry_d;
`endif

    logic              enable_s, clr_err_s, accept_s, err_set_s, ptr_last_s;
    logic [NUM_CH-1:0] mask_s, grant_s;
    logic [PTR_W:0]    ptr_inc_s;
    logic [dw-1:0]     sample_s;
    logic [aw-1:0]     slot_adr_s;
    logic              unused_s;

    assign enable_s  = control_reg[ENABLE_BIT];
    assign clr_err_s = control_reg[CLR_ERR_BIT];
    assign mask_s    = control_reg[MASK_LSB +: NUM_CH];

    // Pointer at or past the last slot (also covers a shrunken buffer) wraps on ack.
    assign ptr_inc_s  = {1'b0, wr_ptr_q} + {{PTR_W{1'b0}}, 1'b1};
    assign ptr_last_s = (ptr_inc_s >= {1'b0, buf_words});
    assign slot_adr_s = base_addr + aw'({wr_ptr_q, 2'b00});

    wb_daq_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk    (wb_clk),
        .rst    (wb_rst),
        .req    (ch_valid),
        .mask   (mask_s),
        .accept (accept_s),
        .grant  (grant_s)
    );

    assign accept_s = (state_q == ST_ARB) && enable_s && (|grant_s);
    assign ch_ready = accept_s ? grant_s : {NUM_CH{1'b0}};

    // Data of the granted channel (grant is one-hot).
    always_comb begin
        sample_s = {dw{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            sample_s = sample_s | (ch_data[i*dw +: dw] & {dw{grant_s[i]}});
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        wrap_d    = 1'b0;
        err_set_s = 1'b0;
`ifdef WB_DAQ_ERR_RETRY_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enable_s && (buf_words != {PTR_W{1'b0}})) begin
                    state_d = ST_ARB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (!enable_s) begin
                    state_d = ST_IDLE;
                end else if (accept_s) begin
                    state_d = ST_WRITE;
                    adr_d   = slot_adr_s;
                    dat_d   = sample_s;
`ifdef WB_DAQ_ERR_RETRY_EN
                    retry_d = 8'd0;
`endif
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_WRITE: begin
                // ack takes priority over a coincident err or rty
                if (wb_ack_i) begin
                    wr_ptr_d = ptr_last_s ? {PTR_W{1'b0}} : ptr_inc_s[PTR_W-1:0];
                    wrap_d   = ptr_last_s;
                    state_d  = enable_s ? ST_ARB : ST_IDLE;
                end else if (wb_err_i) begin
`ifdef WB_DAQ_ERR_RETRY_EN
                    if (retry_q < 8'(MAX_RETRY)) begin
                        retry_d = retry_q + 8'd1;
                        state_d = ST_RETRY_GAP;
                    end else begin
                        err_set_s = 1'b1;
                        state_d   = enable_s ? ST_ARB : ST_IDLE;
                    end
`else
                    err_set_s = 1'b1;
                    state_d   = enable_s ? ST_ARB : ST_IDLE;
`endif
                end else if (wb_rty_i) begin
                    state_d = ST_RETRY_GAP;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_RETRY_GAP: begin
                state_d = ST_WRITE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        cyc_d = (state_d == ST_WRITE);
        err_d = err_set_s | (err_q & ~clr_err_s);
    end

    // State and output registers.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= {PTR_W{1'b0}};
            adr_q    <= {aw{1'b0}};
            dat_q    <= {dw{1'b0}};
            cyc_q    <= 1'b0;
            err_q    <= 1'b0;
            wrap_q   <= 1'b0;
`ifdef WB_DAQ_ERR_RETRY_EN
            retry_q  <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            cyc_q    <= cyc_d;
            err_q    <= err_d;
            wrap_q   <= wrap_d;
`ifdef WB_DAQ_ERR_RETRY_EN
            retry_q  <= retry_d;
`endif
        end
    end

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = cyc_q;
    assign wb_sel_o = cyc_q ? SEL_ALL : 4'h0;
    assign wb_cti_o = CTI_CLASSIC;
    assign wb_bte_o = BTE_LINEAR;
    assign wr_ptr   = wr_ptr_q;
    assign busy     = (state_q != ST_IDLE);
    assign err_o    = err_q;
    assign wrap_irq = wrap_q;

`ifdef WB_DAQ_ERR_RETRY_EN
    assign unused_s = ^{wb_dat_i, control_reg};
`else
    assign unused_s = ^{wb_dat_i, control_reg, 8'(MAX_RETRY)};
`endif

endmodule

// File: tb/tb_wb_daq_dma_master.sv
// Self-checking bench for wb_daq_dma_master: transaction-level scoreboard plus
// directed scenarios with literal expectations.
module tb_wb_daq_dma_master;

    localparam int DW = 32, AW = 32, NCH = 4, PW = 16, MAXR = 3;
`ifdef WB_DAQ_ERR_RETRY_EN
    localparam bit RETRY_BUILD    = 1'b1;
    localparam int EXP_ERR_ISSUES = 4;
`else
    localparam bit RETRY_BUILD    = 1'b0;
    localparam int EXP_ERR_ISSUES = 1;
`endif
    localparam int R_ACK = 0, R_ERR = 1, R_RTY = 2, R_ACKERR = 3;

    logic clk, rst;
    logic [AW-1:0] wb_adr_o; logic [DW-1:0] wb_dat_o; logic [3:0] wb_sel_o;
    logic wb_we_o, wb_cyc_o, wb_stb_o; logic [2:0] wb_cti_o; logic [1:0] wb_bte_o;
    logic [DW-1:0] wb_dat_i; logic wb_ack_i, wb_err_i, wb_rty_i;
    logic [DW-1:0] control_reg; logic [AW-1:0] base_addr; logic [PW-1:0] buf_words;
    logic [NCH-1:0] ch_valid, ch_ready; logic [NCH*DW-1:0] ch_data;
    logic [PW-1:0] wr_ptr; logic busy, err_o, wrap_irq;

    wb_daq_dma_master #(.dw(DW), .aw(AW), .NUM_CH(NCH), .PTR_W(PW), .MAX_RETRY(MAXR)) dut (
        .wb_clk(clk), .wb_rst(rst),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .control_reg(control_reg), .base_addr(base_addr), .buf_words(buf_words),
        .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
        .wr_ptr(wr_ptr), .busy(busy), .err_o(err_o), .wrap_irq(wrap_irq)
    );

    int n_checks = 0, n_errors = 0;

    // Model state
    logic [DW-1:0] src_q [NCH][$];
    logic [AW-1:0] exp_adr[$];
    logic [DW-1:0] exp_dat[$];
    logic [AW-1:0] ack_adr_log[$];
    int grant_log[$];
    int scr_code[$], scr_delay[$];
    int m_ptr, m_last, m_tries, attempts, wrap_count, pend_pop;
    int cur_code, cur_delay, wait_cnt;
    bit m_err, m_exp_stb, m_exp_gap, m_exp_wrap, have_cur, err_set;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NCH-1:0] cand, input int last);
        for (int off = 1; off <= NCH; off++) begin
            if (cand[(last + off) % NCH]) return (last + off) % NCH;
        end
        return -1;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Per-cycle scoreboard and bus responder (negedge), source update after posedge.
    task automatic monitor_cycle();
        logic [NCH-1:0] cand, exp_ready;
        int pick;
        chk("wr_ptr", wr_ptr, m_ptr);
        chk("err_o", err_o, m_err);
        chk("wrap_irq", wrap_irq, m_exp_wrap);
        chk("cyc_eq_stb", wb_cyc_o, wb_stb_o);
        if (m_exp_stb) chk("stb_latency", wb_stb_o, 1'b1);
        if (m_exp_gap) chk("retry_gap", wb_stb_o, 1'b0);
        m_exp_stb = 0; m_exp_gap = 0; m_exp_wrap = 0; err_set = 0;
        cand = ch_valid & control_reg[8 +: NCH];
        if (ch_ready != '0) begin
            pick = rr_pick(cand, m_last);
            exp_ready = '0;
            if (pick >= 0) exp_ready[pick] = 1'b1;
            chk("grant", ch_ready, exp_ready);
            chk("grant_enable", control_reg[0], 1'b1);
            chk("grant_bus_idle", {wb_stb_o, exp_adr.size() != 0}, 2'b00);
            if (pick >= 0) begin
                exp_adr.push_back(base_addr + AW'(m_ptr * 4));
                exp_dat.push_back(src_q[pick][0]);
                grant_log.push_back(pick);
                m_last = pick; m_tries = 0; m_exp_stb = 1; pend_pop = pick;
            end
        end
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        if (wb_stb_o) begin
            if (exp_adr.size() == 0) begin
                chk("stb_without_grant", wb_stb_o, 1'b0);
            end else begin
                chk("adr", wb_adr_o, exp_adr[0]);
                chk("dat", wb_dat_o, exp_dat[0]);
                chk("sel_we_cti_bte", {wb_sel_o, wb_we_o, wb_cti_o, wb_bte_o}, {4'hF, 1'b1, 3'b000, 2'b00});
                chk("busy_in_write", busy, 1'b1);
                if (!have_cur) begin
                    attempts++;
                    if (scr_code.size() > 0) begin
                        cur_code = scr_code.pop_front(); cur_delay = scr_delay.pop_front();
                    end else begin
                        cur_code = R_ACK; cur_delay = 0;
                    end
                    have_cur = 1; wait_cnt = 0;
                end
                if (wait_cnt == cur_delay) begin
                    have_cur = 0;
                    wb_ack_i = (cur_code == R_ACK) || (cur_code == R_ACKERR);
                    wb_err_i = (cur_code == R_ERR) || (cur_code == R_ACKERR);
                    wb_rty_i = (cur_code == R_RTY);
                    if (wb_ack_i) begin
                        ack_adr_log.push_back(exp_adr.pop_front());
                        void'(exp_dat.pop_front());
                        if (m_ptr + 1 >= int'(buf_words)) begin
                            m_ptr = 0; m_exp_wrap = 1; wrap_count++;
                        end else begin
                            m_ptr = m_ptr + 1;
                        end
                    end else if (wb_err_i) begin
                        if (RETRY_BUILD && m_tries < MAXR) begin
                            m_tries++; m_exp_gap = 1;
                        end else begin
                            void'(exp_adr.pop_front()); void'(exp_dat.pop_front()); err_set = 1;
                        end
                    end else begin
                        m_exp_gap = 1;
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
        m_err = err_set | (m_err & ~control_reg[1]);
    endtask

    initial begin
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
        ch_valid = '0; ch_data = '0; pend_pop = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
                m_ptr = 0; m_err = 0; m_last = NCH - 1; m_tries = 0; attempts = 0; wrap_count = 0;
                m_exp_stb = 0; m_exp_gap = 0; m_exp_wrap = 0; have_cur = 0; wait_cnt = 0; pend_pop = -1;
                exp_adr.delete(); exp_dat.delete(); ack_adr_log.delete(); grant_log.delete();
                scr_code.delete(); scr_delay.delete();
                for (int i = 0; i < NCH; i++) src_q[i].delete();
            end else begin
                monitor_cycle();
            end
            @(posedge clk); #1;
            if (pend_pop >= 0) begin
                if (src_q[pend_pop].size() > 0) void'(src_q[pend_pop].pop_front());
                pend_pop = -1;
            end
            for (int i = 0; i < NCH; i++) begin
                ch_valid[i] = (src_q[i].size() > 0);
                ch_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic reset_dut(input logic [DW-1:0] ctl, input logic [AW-1:0] base, input logic [PW-1:0] words);
        rst = 1'b1; control_reg = ctl; base_addr = base; buf_words = words;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic script(input int code, input int delay);
        scr_code.push_back(code); scr_delay.push_back(delay);
    endtask

    task automatic wait_grants(input string name, input int n, input int budget);
        bit done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            tick(1);
            done = (grant_log.size() >= n) && (exp_adr.size() == 0) && !wb_stb_o;
        end
        chk(name, done, 1'b1);
    endtask

    logic [AW-1:0] ring_adr [6];
    int order_f [5];
    int order_5 [4];

    initial begin
        ring_adr = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1000, 32'h1004};
        order_f  = '{0, 1, 2, 3, 0};
        order_5  = '{0, 2, 0, 2};
        rst = 1'b1; control_reg = '0; base_addr = '0; buf_words = '0;
        #3;
        chk("reset_outputs", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, ch_ready, busy, err_o, wrap_irq, wr_ptr, wb_adr_o, wb_dat_o},
            {1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0});
        tick(2);

        // Ring of four words, six samples on channel 0
        reset_dut(32'h0000_0101, 32'h1000, 16'd4);
        for (int k = 0; k < 6; k++) src_q[0].push_back(32'hA000_0000 + k);
        wait_grants("ring_done", 6, 200);
        for (int k = 0; k < 6; k++) chk($sformatf("ring_adr%0d", k), ack_adr_log.size() > k ? ack_adr_log[k] : 32'hDEAD, ring_adr[k]);
        chk("ring_wrap_count", wrap_count, 1);
        chk("ring_wr_ptr", wr_ptr, 16'd2);

        // Round robin, all four channels unmasked
        reset_dut(32'h0000_0F01, 32'h4000, 16'd16);
        for (int ch = 0; ch < NCH; ch++) for (int k = 0; k < 2; k++) src_q[ch].push_back(32'hB000_0000 + ch * 16 + k);
        wait_grants("rr_f_done", 5, 200);
        control_reg = 32'h0000_0F00;
        tick(4);
        chk("rr_f_count", grant_log.size(), 5);
        for (int k = 0; k < 5; k++) chk($sformatf("rr_f_grant%0d", k), grant_log.size() > k ? grant_log[k] : -1, order_f[k]);

        // Round robin, mask 0x5
        reset_dut(32'h0000_0501, 32'h4000, 16'd16);
        for (int ch = 0; ch < NCH; ch++) for (int k = 0; k < 2; k++) src_q[ch].push_back(32'hC000_0000 + ch * 16 + k);
        wait_grants("rr_5_done", 4, 200);
        tick(6);
        chk("rr_5_count", grant_log.size(), 4);
        for (int k = 0; k < 4; k++) chk($sformatf("rr_5_grant%0d", k), grant_log.size() > k ? grant_log[k] : -1, order_5[k]);

        // Persistent bus error, then clear_err
        reset_dut(32'h0000_0101, 32'h2000, 16'd8);
        for (int k = 0; k < 4; k++) script(R_ERR, 0);
        src_q[0].push_back(32'hE000_0001);
        for (int c = 0; c < 60 && !err_o; c++) tick(1);
        tick(3);
        chk("err_issues", attempts, EXP_ERR_ISSUES);
        chk("err_sticky", err_o, 1'b1);
        chk("err_wr_ptr", wr_ptr, 16'd0);
        control_reg = 32'h0000_0103;
        tick(1);
        control_reg = 32'h0000_0101;
        tick(1);
        chk("err_cleared", err_o, 1'b0);

        // Retry twice then ack; then ack coincident with err
        reset_dut(32'h0000_0101, 32'h3000, 16'd8);
        script(R_RTY, 0); script(R_RTY, 0); script(R_ACK, 0); script(R_ACKERR, 0);
        src_q[0].push_back(32'h5555_0001); src_q[0].push_back(32'h5555_0002);
        wait_grants("rty_done", 2, 100);
        tick(2);
        chk("rty_attempts", attempts, 4);
        chk("rty_wr_ptr", wr_ptr, 16'd2);
        chk("ackerr_no_err", err_o, 1'b0);

        // Enable dropped while the write is outstanding
        reset_dut(32'h0000_0101, 32'h1000, 16'd8);
        script(R_ACK, 3);
        src_q[0].push_back(32'h7777_0001);
        for (int c = 0; c < 20 && !wb_stb_o; c++) tick(1);
        control_reg = 32'h0000_0100;
        wait_grants("dis_done", 1, 50);
        chk("dis_busy", busy, 1'b0);
        chk("dis_wr_ptr", wr_ptr, 16'd1);
        src_q[0].push_back(32'h7777_0002);
        tick(6);
        chk("dis_no_grant", grant_log.size(), 1);
        chk("dis_still_idle", {busy, wb_stb_o}, 2'b00);

        // Asynchronous reset in the middle of a write
        reset_dut(32'h0000_0101, 32'h1000, 16'd4);
        script(R_ACK, 0); script(R_ACK, 30);
        src_q[0].push_back(32'h9999_0001); src_q[0].push_back(32'h9999_0002);
        for (int c = 0; c < 40 && !(wb_stb_o && wr_ptr == 16'd1); c++) tick(1);
        chk("pre_rst_ptr", wr_ptr, 16'd1);
        chk("pre_rst_stb", wb_stb_o, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst", {wb_cyc_o, wb_stb_o, wr_ptr, err_o, busy}, {1'b0, 1'b0, 16'h0, 1'b0, 1'b0});
        tick(2);
        control_reg = 32'h0000_0F01;
        rst = 1'b0;
        src_q[3].push_back(32'h3333_0000); src_q[1].push_back(32'h1111_0000); src_q[0].push_back(32'h0000_0000);
        wait_grants("post_rst_done", 3, 100);
        chk("post_rst_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
